// File: rtl/control_seq_pkg.sv
// Shared definitions for the multi-cycle control sequencer: state codes,
// opcode constants and a small helper used by the transition logic.
package control_seq_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        STATE_FETCH    = 4'd0,
        STATE_REGLOAD  = 4'd1,
        STATE_ALUOP    = 4'd2,
        STATE_LOAD     = 4'd3,
        STATE_STORE    = 4'd4,
        STATE_REGSTORE = 4'd5,
        STATE_NEXT     = 4'd6,
        STATE_IRQ      = 4'd7,
        STATE_HALT     = 4'd8
    } state_t;

    // Opcode map for the 4-bit instruction nibble. Anything not listed here
    // (and not flagged as an ALU op by the decoder) executes as a NOP.
    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_LOADLO = 4'h1;
    localparam logic [3:0] OP_LOADHI = 4'h2;
    localparam logic [3:0] OP_LOAD   = 4'h3;
    localparam logic [3:0] OP_STORE  = 4'h4;
    localparam logic [3:0] OP_IN     = 4'h5;
    localparam logic [3:0] OP_OUT    = 4'h6;
    localparam logic [3:0] OP_JMP    = 4'h7;
    localparam logic [3:0] OP_BR     = 4'h8;
    localparam logic [3:0] OP_HALT   = 4'h9;

    // True for the states that wait on the memory handshake. FETCH only
    // counts when the fetch actually waits for memory.
    function automatic logic is_mem_step(input state_t st, input logic fetch_waits);
        is_mem_step = (st == STATE_LOAD) || (st == STATE_STORE) ||
                      ((st == STATE_FETCH) && fetch_waits);
    endfunction

endpackage

// File: rtl/wait_timer.sv
// Wait-state counter for memory steps. Held at zero while clear is high,
// advances on count_en, and flags the last allowed wait cycle.
module wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic terminal
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int LAST_INT = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
    localparam logic [CW-1:0] LAST = CW'(LAST_INT);

    logic [CW-1:0] count;

    // Count wait cycles; clearing takes priority so every step starts at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en) begin
            count <= count + CW'(1);
        end
    end

    assign terminal = (TIMEOUT != 0) && (count == LAST);

endmodule

// File: rtl/control_seq.sv
// Multi-cycle control sequencer: walks each instruction through fetch,
// register load, ALU, memory and writeback, with memory wait handling,
// a wait-state timeout, HALT and interrupt entry between instructions.
module control_seq
    import control_seq_pkg::*;
#(
    parameter int OPW        = 4,
    parameter int TIMEOUT    = 16,
    parameter int FETCH_WAIT = 1,
    parameter int IRQ_WAKE   = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [OPW-1:0] opcode,
    input  logic           isaluop,
    input  logic           mem_ready,
    input  logic           irq,
    input  logic           irq_en,
    output logic           do_fetch,
    output logic           do_regload,
    output logic           do_aluop,
    output logic           do_memload,
    output logic           do_memstore,
    output logic           do_regstore,
    output logic           do_next,
    output logic           do_irq,
    output logic           halted,
    output logic           mem_timeout,
    output logic [3:0]     state_o
);

    localparam logic FETCH_WAITS = (FETCH_WAIT != 0);
    localparam logic IRQ_WAKES   = (IRQ_WAKE != 0);

    state_t state;
    logic   in_mem_step;
    logic   wait_terminal;
    logic   wait_expired;
    logic   irq_take;
    logic   op_load;
    logic   op_store;
    logic   op_regimm;
    logic   op_branch;
    logic   op_halt;

    assign in_mem_step  = is_mem_step(state, FETCH_WAITS);
    assign wait_expired = wait_terminal && !mem_ready;
    assign irq_take     = irq && irq_en;

    assign op_load   = (opcode == OPW'(OP_LOAD))   || (opcode == OPW'(OP_IN));
    assign op_store  = (opcode == OPW'(OP_STORE))  || (opcode == OPW'(OP_OUT));
    assign op_regimm = (opcode == OPW'(OP_LOADLO)) || (opcode == OPW'(OP_LOADHI));
    assign op_branch = (opcode == OPW'(OP_JMP))    || (opcode == OPW'(OP_BR));
    assign op_halt   = (opcode == OPW'(OP_HALT));

    wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (!in_mem_step),
        .count_en (in_mem_step && !mem_ready),
        .terminal (wait_terminal)
    );

    // Main sequencer: state register plus the sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= STATE_FETCH;
            mem_timeout <= 1'b0;
        end else begin
            case (state)
                STATE_FETCH: begin
                    if (!FETCH_WAITS || mem_ready) begin
                        state <= STATE_REGLOAD;
                    end else if (wait_expired) begin
                        state       <= STATE_HALT;
                        mem_timeout <= 1'b1;
                    end
                end
                STATE_REGLOAD: begin
                    if (isaluop) begin
                        state <= STATE_ALUOP;
                    end else if (op_load) begin
                        state <= STATE_LOAD;
                    end else if (op_store) begin
                        state <= STATE_STORE;
                    end else if (op_regimm) begin
                        state <= STATE_REGSTORE;
                    end else if (op_branch) begin
                        state <= STATE_NEXT;
                    end else if (op_halt) begin
                        state <= STATE_HALT;
                    end else begin
                        state <= STATE_NEXT;
                    end
                end
                STATE_ALUOP: begin
                    state <= STATE_REGSTORE;
                end
                STATE_LOAD: begin
                    if (mem_ready) begin
                        state <= STATE_REGSTORE;
                    end else if (wait_expired) begin
                        state       <= STATE_HALT;
                        mem_timeout <= 1'b1;
                    end
                end
                STATE_STORE: begin
                    if (mem_ready) begin
                        state <= STATE_NEXT;
                    end else if (wait_expired) begin
                        state       <= STATE_HALT;
                        mem_timeout <= 1'b1;
                    end
                end
                STATE_REGSTORE: begin
                    state <= STATE_NEXT;
                end
                STATE_NEXT: begin
                    state <= irq_take ? STATE_IRQ : STATE_FETCH;
                end
                STATE_IRQ: begin
                    state <= STATE_FETCH;
                end
                STATE_HALT: begin
                    if (IRQ_WAKES && irq_take) begin
                        state <= STATE_IRQ;
                    end
                end
                default: begin
                    state <= STATE_FETCH;
                end
            endcase
        end
    end

    assign do_fetch    = (state == STATE_FETCH);
    assign do_regload  = (state == STATE_REGLOAD);
    assign do_aluop    = (state == STATE_ALUOP);
    assign do_memload  = (state == STATE_LOAD);
    assign do_memstore = (state == STATE_STORE);
    assign do_regstore = (state == STATE_REGSTORE);
    assign do_next     = (state == STATE_NEXT);
    assign do_irq      = (state == STATE_IRQ);
    assign halted      = (state == STATE_HALT);
    assign state_o     = state;

endmodule

// File: tb/tb_control_seq.sv
// Scoreboard bench for control_seq: the stimulus thread queues the expected
// state for every cycle, a monitor thread pops and compares at the negedge.
module tb_control_seq;
    import control_seq_pkg::*;

    localparam logic [3:0] S_F  = 4'd0;
    localparam logic [3:0] S_RL = 4'd1;
    localparam logic [3:0] S_AL = 4'd2;
    localparam logic [3:0] S_LD = 4'd3;
    localparam logic [3:0] S_ST = 4'd4;
    localparam logic [3:0] S_RS = 4'd5;
    localparam logic [3:0] S_NX = 4'd6;
    localparam logic [3:0] S_IQ = 4'd7;
    localparam logic [3:0] S_H  = 4'd8;

    logic       clk;
    logic       rst_n;
    logic [3:0] opcode;
    logic       isaluop;
    logic       mem_ready;
    logic       irq;
    logic       irq_en;

    logic do_fetch, do_regload, do_aluop, do_memload;
    logic do_memstore, do_regstore, do_next, do_irq;
    logic halted, mem_timeout;
    logic [3:0] state_o;

    logic nw_fetch, nw_regload, nw_aluop, nw_memload;
    logic nw_memstore, nw_regstore, nw_next, nw_irq;
    logic nw_halted, nw_mem_timeout;
    logic [3:0] nw_state_o;

    typedef struct packed {
        logic [3:0] st;
        logic       tmo;
        logic [3:0] nw_st;
        logic [7:0] idx;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic [7:0] step_idx = 8'd0;

    control_seq #(
        .OPW(4), .TIMEOUT(4), .FETCH_WAIT(1), .IRQ_WAKE(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .isaluop(isaluop),
        .mem_ready(mem_ready), .irq(irq), .irq_en(irq_en),
        .do_fetch(do_fetch), .do_regload(do_regload), .do_aluop(do_aluop),
        .do_memload(do_memload), .do_memstore(do_memstore),
        .do_regstore(do_regstore), .do_next(do_next), .do_irq(do_irq),
        .halted(halted), .mem_timeout(mem_timeout), .state_o(state_o)
    );

    control_seq #(
        .OPW(4), .TIMEOUT(4), .FETCH_WAIT(1), .IRQ_WAKE(0)
    ) dut_nw (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .isaluop(isaluop),
        .mem_ready(mem_ready), .irq(irq), .irq_en(irq_en),
        .do_fetch(nw_fetch), .do_regload(nw_regload), .do_aluop(nw_aluop),
        .do_memload(nw_memload), .do_memstore(nw_memstore),
        .do_regstore(nw_regstore), .do_next(nw_next), .do_irq(nw_irq),
        .halted(nw_halted), .mem_timeout(nw_mem_timeout), .state_o(nw_state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected one-hot strobe vector {fetch..irq} for a state code.
    function automatic logic [7:0] strobes_for(input logic [3:0] st);
        case (st)
            4'd0:    strobes_for = 8'b1000_0000;
            4'd1:    strobes_for = 8'b0100_0000;
            4'd2:    strobes_for = 8'b0010_0000;
            4'd3:    strobes_for = 8'b0001_0000;
            4'd4:    strobes_for = 8'b0000_1000;
            4'd5:    strobes_for = 8'b0000_0100;
            4'd6:    strobes_for = 8'b0000_0010;
            4'd7:    strobes_for = 8'b0000_0001;
            default: strobes_for = 8'b0000_0000;
        endcase
    endfunction

    task automatic compare(input string what, input logic [7:0] idx,
                           input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s step %0d: got %0h, expected %0h", what, idx, act, req);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        compare("state", e.idx, 32'(state_o), 32'(e.st));
        compare("strobes", e.idx,
                32'({do_fetch, do_regload, do_aluop, do_memload,
                     do_memstore, do_regstore, do_next, do_irq}),
                32'(strobes_for(e.st)));
        compare("halted", e.idx, 32'(halted), 32'(e.st == S_H));
        compare("mem_timeout", e.idx, 32'(mem_timeout), 32'(e.tmo));
        compare("nowake_state", e.idx, 32'(nw_state_o), 32'(e.nw_st));
        compare("nowake_strobes", e.idx,
                32'({nw_fetch, nw_regload, nw_aluop, nw_memload,
                     nw_memstore, nw_regstore, nw_next, nw_irq}),
                32'(strobes_for(e.nw_st)));
        compare("nowake_halted", e.idx, 32'(nw_halted), 32'(e.nw_st == S_H));
        compare("nowake_mem_timeout", e.idx, 32'(nw_mem_timeout), 32'(e.tmo));
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic alu,
                                 input logic rdy, input logic i, input logic ie);
        opcode    = op;
        isaluop   = alu;
        mem_ready = rdy;
        irq       = i;
        irq_en    = ie;
    endtask

    // Expectation for the cycle that begins at the next posedge.
    task automatic tick(input logic [3:0] st, input logic tmo, input logic [3:0] nw_st);
        @(posedge clk);
        #1;
        sb.push_back('{st: st, tmo: tmo, nw_st: nw_st, idx: step_idx});
        step_idx++;
    endtask

    // Short reset pulse inside one cycle: both DUTs must drop to FETCH with
    // no clock edge in between.
    task automatic resetPulse();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        sb.push_back('{st: S_F, tmo: 1'b0, nw_st: S_F, idx: step_idx});
        step_idx++;
        #2;
        rst_n = 1'b1;
    endtask

    // Monitor: compare whatever the stimulus queued for this cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        applyStimulus(OP_NOP, 1'b1, 1'b1, 1'b0, 1'b0);
        tick(S_F, 1'b0, S_F);
        rst_n = 1'b1;

        // ALU instruction with memory always ready
        tick(S_RL, 1'b0, S_RL);
        tick(S_AL, 1'b0, S_AL);
        tick(S_RS, 1'b0, S_RS);
        tick(S_NX, 1'b0, S_NX);
        tick(S_F,  1'b0, S_F);

        // LOAD with three wait states; ready on the last allowed cycle wins
        applyStimulus(OP_LOAD, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(S_RL, 1'b0, S_RL);
        mem_ready = 1'b0;
        tick(S_LD, 1'b0, S_LD);
        tick(S_LD, 1'b0, S_LD);
        tick(S_LD, 1'b0, S_LD);
        tick(S_LD, 1'b0, S_LD);
        mem_ready = 1'b1;
        tick(S_RS, 1'b0, S_RS);
        tick(S_NX, 1'b0, S_NX);
        tick(S_F,  1'b0, S_F);

        // LOADLO goes straight to writeback
        applyStimulus(OP_LOADLO, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(S_RL, 1'b0, S_RL);
        tick(S_RS, 1'b0, S_RS);
        tick(S_NX, 1'b0, S_NX);
        tick(S_F,  1'b0, S_F);

        // STORE that never completes: four wait cycles then timeout halt
        applyStimulus(OP_STORE, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(S_RL, 1'b0, S_RL);
        mem_ready = 1'b0;
        tick(S_ST, 1'b0, S_ST);
        tick(S_ST, 1'b0, S_ST);
        tick(S_ST, 1'b0, S_ST);
        tick(S_ST, 1'b0, S_ST);
        tick(S_H,  1'b1, S_H);
        mem_ready = 1'b1;
        tick(S_H,  1'b1, S_H);
        tick(S_H,  1'b1, S_H);
        resetPulse();

        // JMP with interrupt enabled, then with interrupt masked
        applyStimulus(OP_JMP, 1'b0, 1'b1, 1'b1, 1'b1);
        tick(S_RL, 1'b0, S_RL);
        tick(S_NX, 1'b0, S_NX);
        tick(S_IQ, 1'b0, S_IQ);
        tick(S_F,  1'b0, S_F);
        applyStimulus(OP_JMP, 1'b0, 1'b1, 1'b1, 1'b0);
        tick(S_RL, 1'b0, S_RL);
        tick(S_NX, 1'b0, S_NX);
        tick(S_F,  1'b0, S_F);

        // HALT: hold, ignore masked irq, then wake only where enabled
        applyStimulus(OP_HALT, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(S_RL, 1'b0, S_RL);
        for (int i = 0; i < 11; i++) begin
            tick(S_H, 1'b0, S_H);
        end
        irq = 1'b1;
        tick(S_H, 1'b0, S_H);
        tick(S_H, 1'b0, S_H);
        irq_en = 1'b1;
        tick(S_IQ, 1'b0, S_H);
        irq = 1'b0;
        tick(S_F,  1'b0, S_H);
        tick(S_RL, 1'b0, S_H);
        resetPulse();

        // Undecoded opcode after a fetch that waits two cycles
        applyStimulus(4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(S_F,  1'b0, S_F);
        tick(S_F,  1'b0, S_F);
        mem_ready = 1'b1;
        tick(S_RL, 1'b0, S_RL);
        tick(S_NX, 1'b0, S_NX);
        tick(S_F,  1'b0, S_F);

        // Reset pulse landing in the ALUOP cycle aborts the instruction
        applyStimulus(OP_NOP, 1'b1, 1'b1, 1'b0, 1'b0);
        tick(S_RL, 1'b0, S_RL);
        resetPulse();
        tick(S_RL, 1'b0, S_RL);

        @(negedge clk);
        @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_seq.md
Name: control_seq

Overview:
- Parametrised successor to the CPU's multi-cycle control FSM. Sequences each instruction through fetch, register load, ALU, memory and writeback steps, and emits a one-hot step strobe per state.
- Adds over the previous generation:
  - asynchronous reset;
  - variable-latency memory handshake on fetch, load and store;
  - a wait-state timeout;
  - a HALT opcode;
  - interrupt entry at instruction boundaries;
  - a defined path for undecoded opcodes.
- Sits between the instruction register/decoder and the datapath (register file, ALU, memory port, PC).

Parameters:
- OPW, 4, opcode width in bits (matches NIB_WIDTH).
- TIMEOUT, 16, maximum wait cycles per memory step; 0 disables the timeout.
- FETCH_WAIT, 1, when 1 the FETCH state waits for mem_ready; when 0 FETCH lasts exactly one cycle.
- IRQ_WAKE, 1, when 1 an enabled irq exits HALT.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  OPW  current instruction opcode, valid from REGLOAD onward.
- isaluop  in  1  decoder flag: the instruction is an ALU op.
- mem_ready  in  1  memory completion for the current FETCH, LOAD or STORE step.
- irq  in  1  level interrupt request.
- irq_en  in  1  interrupt enable.
- do_fetch, do_regload, do_aluop, do_memload, do_memstore, do_regstore, do_next, do_irq  out  1 each  one-hot step strobes.
- halted  out  1  high while in HALT.
- mem_timeout  out  1  sticky error flag; set when a memory step times out.
- state_o  out  4  current state code, for debug.

Behaviour:
- Reset (asynchronous, active-low): state=FETCH, wait counter=0, mem_timeout=0. Consequently do_fetch=1, all other strobes 0, halted=0.
- Strobes and halted are pure decodes of the state register. They change only after a posedge and are never high simultaneously.
- Transitions:
  - FETCH -> REGLOAD. If FETCH_WAIT=1, waits until mem_ready=1.
  - REGLOAD, by priority:
    - isaluop -> ALUOP;
    - OP_LOAD, OP_IN -> LOAD;
    - OP_STORE, OP_OUT -> STORE;
    - OP_LOADLO, OP_LOADHI -> REGSTORE;
    - OP_JMP, OP_BR -> NEXT;
    - OP_HALT -> HALT;
    - any other opcode -> NEXT (treated as a NOP; never hangs).
  - ALUOP -> REGSTORE.
  - LOAD -> REGSTORE, on a cycle with mem_ready=1.
  - STORE -> NEXT, on a cycle with mem_ready=1.
  - REGSTORE -> NEXT.
  - NEXT -> IRQ if irq&&irq_en, else FETCH.
  - IRQ -> FETCH. IRQ lasts one cycle; do_irq tells the datapath to save the PC and load the vector.
  - HALT -> IRQ if IRQ_WAKE&&irq&&irq_en; otherwise stays in HALT. Reset also exits HALT.
- Memory steps with zero wait states: if mem_ready=1 on the first cycle of the step, the step lasts one cycle.
- Wait counter:
  - cleared on entry to any memory step;
  - increments on each cycle of the step in which mem_ready=0;
  - when TIMEOUT!=0 and counter==TIMEOUT-1 with mem_ready still 0 -> HALT and mem_timeout<=1.
  - A mem_ready arriving on that same cycle wins: normal transition, no error.
  - Counter width is clog2(TIMEOUT+1), minimum 1 bit.
- mem_timeout clears only on reset.
- irq is sampled only in NEXT and HALT; it is never taken mid-instruction.
- Reset asserted mid-instruction aborts the instruction immediately (asynchronous). The first post-reset cycle is FETCH.
- State encoding (4 bits): FETCH=0, REGLOAD=1, ALUOP=2, LOAD=3, STORE=4, REGSTORE=5, NEXT=6, IRQ=7, HALT=8. Codes 9-15 are illegal; if reached -> FETCH on the next edge.

Decomposition:
- Shared package/include (extends parameters.v): STATE_* codes above (4-bit), OP_* opcode constants including new OP_HALT, state width constant.
- One natural sub-module: wait_timer. Its ports are clear, count enable, terminal-count output; it is parametrised by TIMEOUT.
- All transition logic stays in control_seq.

Test Plan:
- ALU op, mem_ready tied 1: reset release -> strobe sequence fetch, regload, aluop, regstore, next, fetch on consecutive cycles (5-cycle instruction).
- OP_LOAD with mem_ready low for 3 cycles in LOAD -> do_memload high for 4 cycles, then regstore and next; mem_timeout=0.
- TIMEOUT=4, OP_STORE, mem_ready never asserted -> do_memstore high for exactly 4 cycles, then halted=1 and mem_timeout=1. These persist until rst_n=0, which gives do_fetch=1 and mem_timeout=0 asynchronously.
- OP_JMP with irq=1, irq_en=1 -> fetch, regload, next, irq, fetch. Same with irq_en=0 -> no do_irq.
- OP_HALT -> halted=1, held for 10 cycles. Then irq=1 with irq_en=1 -> do_irq for one cycle, then do_fetch. Repeat with IRQ_WAKE=0 -> stays halted.
- Undefined opcode (e.g. 4'hF with no match, isaluop=0) -> regload, next, fetch. Also rst_n pulsed low during ALUOP -> state_o=0 within the same cycle.
